// File: rtl/hex_display_arbiter.sv
// Two-requester arbiter for a four-digit hex display bank with minimum hold time.
// Optional leading-zero blanking is enabled by defining HEX_ZERO_BLANK_EN.
module hex_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [15:0] hex_data,
  output logic [3:0]  hex_blank
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

`ifdef HEX_ZERO_BLANK_EN
  // Blank leading zero digits 3..1; digit 0 always stays lit.
  function automatic logic [3:0] zero_blank(input logic [15:0] d);
    logic [3:0] b;
    b = 4'b0000;
    if (d[15:12] == 4'h0) begin
      b[3] = 1'b1;
      if (d[11:8] == 4'h0) begin
        b[2] = 1'b1;
        if (d[7:4] == 4'h0) begin
          b[1] = 1'b1;
        end else begin
          b[1] = 1'b0;
        end
      end else begin
        b[2] = 1'b0;
      end
    end else begin
      b[3] = 1'b0;
    end
    return b;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;   // 1 = B favoured on next contention
  logic [15:0] data_q, data_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic [3:0]  blank_q, blank_d;
  logic        grant_a_s, grant_b_s;

  // Next-state, hold counter, round-robin pointer and registered output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    blank_d   = 4'b1111;

    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || !ptr_q)) begin
          grant_a_s = 1'b1;
        end else if (req_b) begin
          grant_b_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_A: begin
        if (cnt_q != 8'd0) begin
          cnt_d  = cnt_q - 8'd1;
          data_d = req_a ? data_a : data_q;
        end else if (req_b) begin
          grant_b_s = 1'b1;
        end else if (req_a) begin
          data_d = data_a;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_B: begin
        if (cnt_q != 8'd0) begin
          cnt_d  = cnt_q - 8'd1;
          data_d = req_b ? data_b : data_q;
        end else if (req_a) begin
          grant_a_s = 1'b1;
        end else if (req_b) begin
          data_d = data_b;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Every grant, fresh or handover, reloads the hold and flips priority.
    if (grant_a_s) begin
      state_d = OWN_A;
      cnt_d   = HOLD_LOAD;
      ptr_d   = 1'b1;
      data_d  = data_a;
    end else if (grant_b_s) begin
      state_d = OWN_B;
      cnt_d   = HOLD_LOAD;
      ptr_d   = 1'b0;
      data_d  = data_b;
    end else begin
      ptr_d = ptr_q;
    end

    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
    if (state_d == IDLE) begin
      blank_d = 4'b1111;
    end else begin
`ifdef HEX_ZERO_BLANK_EN
      blank_d = zero_blank(data_d);
`else
      blank_d = 4'b0000;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ptr_q   <= 1'b0;
      data_q  <= 16'h0000;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      blank_q <= 4'b1111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      blank_q <= blank_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign hex_data  = data_q;
  assign hex_blank = blank_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed scoreboard bench for hex_display_arbiter with HOLD_CYCLES = 4.
// Expected blanking follows HEX_ZERO_BLANK_EN when the bench is built with it.
module tb_hex_display_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic [15:0] data_a = 16'h0000;
  logic        req_b = 1'b0;
  logic [15:0] data_b = 16'h0000;
  logic        gnt_a, gnt_b;
  logic [15:0] hex_data;
  logic [3:0]  hex_blank;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        ga;
    logic        gb;
    logic [15:0] d;
    logic [3:0]  b;
  } exp_t;

  exp_t sb_q[$];

  hex_display_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .data_a   (data_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .hex_data (hex_data),
    .hex_blank(hex_blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, clock, then compare.
  task automatic step(input string tag, input logic rst, input logic ra, input logic [15:0] da,
                      input logic rb, input logic [15:0] db,
                      input logic ega, input logic egb, input logic [15:0] ed,
                      input logic [3:0] eb_plain, input logic [3:0] eb_zb);
    exp_t e;
    reset  = rst;
    req_a  = ra;
    data_a = da;
    req_b  = rb;
    data_b = db;
    e.tag = tag;
    e.ga  = ega;
    e.gb  = egb;
    e.d   = ed;
`ifdef HEX_ZERO_BLANK_EN
    e.b = eb_zb;
`else
    e.b = eb_plain;
`endif
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_gnt_a"}, {15'd0, gnt_a}, {15'd0, e.ga});
      chk({e.tag, "_gnt_b"}, {15'd0, gnt_b}, {15'd0, e.gb});
      chk({e.tag, "_data"}, hex_data, e.d);
      chk({e.tag, "_blank"}, {12'd0, hex_blank}, {12'd0, e.b});
    end
  endtask

  initial begin
    //    tag            rst  ra    da        rb    db        ga    gb    data      plain    zero-blank
    step("reset",        1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'b1111);
    step("grant_a",      1'b0, 1'b1, 16'h12AF, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h12AF, 4'b0000, 4'b0000);
    step("freeze1",      1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h12AF, 4'b0000, 4'b0000);
    step("freeze2",      1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h12AF, 4'b0000, 4'b0000);
    step("freeze3",      1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h12AF, 4'b0000, 4'b0000);
    step("to_idle",      1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AF, 4'b1111, 4'b1111);
    step("rr_b",         1'b0, 1'b1, 16'h00C3, 1'b1, 16'h5678, 1'b0, 1'b1, 16'h5678, 4'b0000, 4'b0000);
    step("follow_b1",    1'b0, 1'b1, 16'h00C3, 1'b1, 16'h9ABC, 1'b0, 1'b1, 16'h9ABC, 4'b0000, 4'b0000);
    step("follow_b2",    1'b0, 1'b1, 16'h1111, 1'b1, 16'h0BCD, 1'b0, 1'b1, 16'h0BCD, 4'b0000, 4'b1000);
    step("hold_b_last",  1'b0, 1'b1, 16'h2222, 1'b1, 16'h0BCD, 1'b0, 1'b1, 16'h0BCD, 4'b0000, 4'b1000);
    step("handover_a",   1'b0, 1'b1, 16'h00C3, 1'b1, 16'h0BCD, 1'b1, 1'b0, 16'h00C3, 4'b0000, 4'b1100);
    step("zero_a1",      1'b0, 1'b1, 16'h0000, 1'b0, 16'h3333, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b1110);
    step("zero_a2",      1'b0, 1'b1, 16'h0000, 1'b0, 16'h4444, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b1110);
    step("zero_a3",      1'b0, 1'b1, 16'h0000, 1'b0, 16'h5555, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b1110);
    step("stay_owned",   1'b0, 1'b1, 16'h4321, 1'b0, 16'h6666, 1'b1, 1'b0, 16'h4321, 4'b0000, 4'b0000);
    step("handover_b",   1'b0, 1'b0, 16'h8888, 1'b1, 16'h7777, 1'b0, 1'b1, 16'h7777, 4'b0000, 4'b0000);
    step("own_b_cnt2",   1'b0, 1'b0, 16'h8888, 1'b1, 16'h7777, 1'b0, 1'b1, 16'h7777, 4'b0000, 4'b0000);
    step("reset_mid_b",  1'b1, 1'b1, 16'h8888, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'b1111);
    step("post_reset_b", 1'b0, 1'b0, 16'h8888, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 4'b0000, 4'b0000);
    step("reset_again",  1'b1, 1'b0, 16'h8888, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'b1111);
    step("grant_a_one",  1'b0, 1'b1, 16'h0001, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h0001, 4'b0000, 4'b1110);
    step("reset_dom",    1'b1, 1'b1, 16'h0ABC, 1'b1, 16'h0DEF, 1'b0, 1'b0, 16'h0000, 4'b1111, 4'b1111);
    step("ptr_reset_a",  1'b0, 1'b1, 16'h0ABC, 1'b1, 16'h0DEF, 1'b1, 1'b0, 16'h0ABC, 4'b0000, 4'b1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
